// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: unsigned 8x8 shift-add multiply driven through the shared 74181-pair ALU.
// One add-and-shift step per RUN cycle; the 17-bit {carry, F} sum is shifted right into {hi, lo}.
module alu_mul_sequencer #(
    parameter logic [3:0] SEL_ADD         = 4'b0110,
    parameter logic       MODE_ARITH      = 1'b0,
    parameter logic       CIN_NONE        = 1'b1,
    parameter bit         COUT_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        product_zero,
    output logic        alu_mode,
    output logic [3:0]  alu_selector,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_f,
    input  logic        alu_carry_out,
    input  logic        alu_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [7:0] mcand, hi, lo;
    logic [2:0] cnt;
    logic carry, unused_ok;
    logic [15:0] sum;
    assign unused_ok = alu_zero;
    assign carry = COUT_ACTIVE_LOW ? ~alu_carry_out : alu_carry_out;
    assign sum = {carry, alu_f, lo[7:1]};
    assign alu_mode = MODE_ARITH;
    assign alu_selector = SEL_ADD;
    assign alu_carry_in = CIN_NONE;
    assign alu_a = hi;
    assign alu_b = lo[0] ? mcand : 8'h00;
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        busy = state != IDLE;
        done = state == DONE;
        case (state)
            IDLE: state_next = start ? RUN : IDLE;
            RUN: state_next = (cnt == 3'd7) ? DONE : RUN;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand <= 8'h00;
            hi <= 8'h00;
            lo <= 8'h00;
            cnt <= 3'd0;
            product <= 16'h0000;
            product_zero <= 1'b1;
        end else if (state == IDLE && start) begin
            mcand <= multiplicand;
            lo <= multiplier;
            hi <= 8'h00;
            cnt <= 3'd0;
        end else if (state == RUN) begin
            {hi, lo} <= sum;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                product <= sum;
                product_zero <= sum == 16'h0000;
            end
        end
    end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller that runs an unsigned 8x8 shift-add multiply on the shared 8-bit 74181-pair ALU and returns a 16-bit product. Each cycle it drives the ALU's mode, selector, operand and carry-in lines, then captures the combinational F and CarryOut into its own working registers. It sits between the CPU control unit, which issues start and collects the product, and the existing ALU instance, which it owns while busy. It uses a start/busy/done handshake.

Parameters:
SEL_ADD, 4'b0110, selector value that makes the ALU compute A plus B (the ALU inverts the selector internally, so the 74181 sees S=1001).
MODE_ARITH, 1'b0, ALU Mode value for arithmetic.
CIN_NONE, 1'b1, ALU CarryIn value meaning "no carry in" (74181 Cn is active-low with active-high data).
COUT_ACTIVE_LOW, 1, 1 means carry = ~alu_carry_out; 0 means carry = alu_carry_out.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request; sampled only in IDLE
multiplicand  in  8  operand A, latched when start is accepted
multiplier  in  8  operand B, latched when start is accepted
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; product is valid from this cycle on
product  out  16  result register
product_zero  out  1  high when product == 0
alu_mode  out  1  to ALU Mode
alu_selector  out  4  to ALU Selector
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_carry_in  out  1  to ALU CarryIn
alu_f  in  8  from ALU F
alu_carry_out  in  1  from ALU CarryOut
alu_zero  in  1  from ALU ZeroFlag; unused, tied off internally

Behaviour:
- Reset, synchronous and active-high, has priority over everything. It forces state=IDLE, busy=0, done=0, product=0, product_zero=1, and clears all working registers (mcand, hi, lo, cnt[2:0]). Reset asserted mid-operation aborts the multiply and no done pulse follows.
- ALU drive is constant in every state:
  - alu_mode=MODE_ARITH, alu_selector=SEL_ADD, alu_carry_in=CIN_NONE.
  - alu_a=hi.
  - alu_b = lo[0] ? mcand : 8'h00.
- States and transitions:
  - IDLE, on start=1 at edge k:
    - Latch mcand<=multiplicand, lo<=multiplier, hi<=0, cnt<=0.
    - Go to RUN.
    - product is not modified.
  - RUN, each edge:
    - c = carry decoded from alu_carry_out per COUT_ACTIVE_LOW.
    - {hi,lo} <= {c, alu_f, lo[7:1]}, i.e. the 17-bit sum is shifted right one bit.
    - cnt<=cnt+1.
    - When cnt==7, also load product<={c, alu_f, lo[7:1]} and go to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- Latency:
  - start is accepted at edge k.
  - RUN occupies cycles k+1..k+8.
  - done=1 in cycle k+9.
  - busy=1 in cycles k+1..k+9.
  - A new start can be accepted at edge k+10 at the earliest.
- start while busy=1 (RUN or DONE) is ignored; it is neither queued nor an error.
- Operands are sampled only at acceptance. Changes to multiplicand/multiplier during RUN have no effect.
- product and product_zero are registered. They hold their value from done until the next completed operation; accepting a new start does not clear them.
- cnt is 3 bits. Its wrap from 7 to 0 coincides with the RUN->DONE transition, so no extra iteration occurs.
- The product is exact for all 65536 operand pairs. The maximum is 255*255=0xFE01, so there is no overflow.

Test Plan:
- reset, then start with 13 x 11 -> done pulse exactly 9 cycles after the accept edge; product=0x008F; product_zero=0; busy high for 9 cycles.
- 255 x 255 -> product=0xFE01. Also check the per-iteration carry path: c=1 on the iterations where the sum exceeds 0xFF.
- 0 x 200, then 200 x 0 -> product=0x0000 and product_zero=1 for both; alu_b=0 in every RUN cycle of the 200 x 0 case.
- 7 x 9 accepted; 3 cycles later pulse start with 100 x 100; start held high through DONE -> first result 0x003F; the second operation is accepted only on the first IDLE edge and yields 0x2710.
- Assert reset during the 5th RUN cycle of 50 x 60 -> no done; product=0; state IDLE. A following 2 x 3 -> product=0x0006.
- Swap in an ALU model with active-high carry-out and set COUT_ACTIVE_LOW=0 -> 255 x 255 still gives 0xFE01.
